// File: rtl/fmap_row_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fmap_row_writer_pkg
//  Description : Shared state encodings, counter width and map-size helper
//                for the output feature-map row writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fmap_row_writer_pkg;

    localparam int c_cnt_w = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Output extent of a valid (unpadded) strided convolution.
    function automatic int out_dim(input int in_sz, input int f, input int s);
        return (in_sz - f) / s + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fmap_pos_counter.sv
`default_nettype none
// ============================================================================
//  Module      : fmap_pos_counter
//  Description : Half-row position counter (row, half) with clear, advance
//                and a last-half-row flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fmap_pos_counter
    import fmap_row_writer_pkg::*;
#(
    parameter int OH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_clear,
    input  logic                 i_advance,
    output logic [c_cnt_w-1:0]   o_row,
    output logic [c_cnt_w-1:0]   o_col,
    output logic                 o_last
);

    logic [c_cnt_w-1:0] r_row;
    logic               r_col;
    logic               w_last;

    assign w_last = (r_row == c_cnt_w'(OH - 1)) && r_col;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row <= '0;
            r_col <= 1'b0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= 1'b0;
        end else if (i_advance) begin
            if (w_last) begin
                r_row <= '0;
                r_col <= 1'b0;
            end else if (r_col) begin
                r_row <= r_row + c_cnt_w'(1);
                r_col <= 1'b0;
            end else begin
                r_col <= 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = {{(c_cnt_w-1){1'b0}}, r_col};
    assign o_last = w_last;

endmodule
`default_nettype wire

// File: rtl/fmap_row_writer.sv
`default_nettype none
// ============================================================================
//  Module      : fmap_row_writer
//  Description : Accepts half-rows of conv results over valid/ready and
//                places them into a registered output feature map.
//  Revision    : 1.0 - initial release
// ============================================================================
module fmap_row_writer
    import fmap_row_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int F          = 5,
    parameter int S          = 2,
    parameter int K          = 1
) (
    input  logic                                                            clk,
    input  logic                                                            reset_n,
    input  logic                                                            start,
    input  logic                                                            in_valid,
    output logic                                                            in_ready,
    input  logic [0:K*((((W-F)/S)+1)/2)*DATA_WIDTH-1]                       in_data,
    output logic [0:10]                                                     rowNumber,
    output logic [0:10]                                                     column,
    output logic [0:K*(((H-F)/S)+1)*(((W-F)/S)+1)*DATA_WIDTH-1]             out_image,
    output logic                                                            busy,
    output logic                                                            done
);

    localparam int c_oh    = out_dim(H, F, S);
    localparam int c_ow    = out_dim(W, F, S);
    localparam int c_half  = c_ow / 2;
    localparam int c_words = K * c_oh * c_ow;

    if ((c_ow % 2) != 0) begin : g_ow_odd
        $error("fmap_row_writer: output width must be even");
    end

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_busy;
    logic                    r_done;
    logic [c_cnt_w-1:0]      w_row;
    logic [c_cnt_w-1:0]      w_col;
    logic                    w_last;
    logic                    w_accept;
    logic                    w_clear;
    logic [c_words-1:0]      w_we;
    logic [DATA_WIDTH-1:0]   w_wdata [c_words];
    logic [0:c_words*DATA_WIDTH-1] r_image;

    assign w_accept = in_valid && r_in_ready;
    assign w_clear  = (r_state == ST_IDLE) && start;

    fmap_pos_counter #(
        .OH (c_oh)
    ) u_pos (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_clear),
        .i_advance (w_accept),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_COLLECT;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (w_accept && w_last) begin
                        r_state    <= ST_DONE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Each map word has a fixed (row, half) owner; the decoder only matches position.
    for (genvar gk = 0; gk < K; gk++) begin : g_k
        for (genvar gr = 0; gr < c_oh; gr++) begin : g_r
            for (genvar gh = 0; gh < 2; gh++) begin : g_h
                for (genvar gj = 0; gj < c_half; gj++) begin : g_j
                    localparam int c_idx = (gk * c_oh + gr) * c_ow + gh * c_half + gj;
                    localparam int c_src = (gk * c_half + gj) * DATA_WIDTH;
                    assign w_we[c_idx]    = w_accept && (w_row == c_cnt_w'(gr))
                                                     && (w_col == c_cnt_w'(gh));
                    assign w_wdata[c_idx] = in_data[c_src +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_image <= '0;
        end else begin
            for (int i = 0; i < c_words; i++) begin
                if (w_we[i]) begin
                    r_image[i*DATA_WIDTH +: DATA_WIDTH] <= w_wdata[i];
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign rowNumber = w_row;
    assign column    = w_col;
    assign out_image = r_image;

endmodule
`default_nettype wire

// File: tb/tb_fmap_row_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fmap_row_writer
//  Description : Self-checking bench for fmap_row_writer (small and default maps).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fmap_row_writer;

    localparam int DW     = 16;
    localparam int KS     = 2;
    localparam int OH     = 4;
    localparam int OW     = 4;
    localparam int HALF   = 2;
    localparam int S_IN   = KS * HALF * DW;
    localparam int S_OUT  = KS * OH * OW * DW;
    localparam int D_OH   = 14;
    localparam int D_HALF = 7;
    localparam int D_IN   = D_HALF * DW;
    localparam int D_OUT  = D_OH * D_OH * DW;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start, in_valid, in_ready, busy, done;
    logic [0:S_IN-1]    in_data;
    logic [0:10]        rowNumber, column;
    logic [0:S_OUT-1]   out_image;
    logic               d_start, d_in_valid, d_in_ready, d_busy, d_done;
    logic [0:D_IN-1]    d_in_data;
    logic [0:10]        d_row, d_col;
    logic [0:D_OUT-1]   d_image;

    int n_chk  = 0;
    int n_fail = 0;

    logic [0:S_OUT-1]   m_img;
    bit                 m_collect, m_done;
    int                 m_beat;
    logic [0:D_OUT-1]   dm_img;

    always #5 clk = ~clk;

    fmap_row_writer #(.DATA_WIDTH(DW), .H(9), .W(9), .F(3), .S(2), .K(KS)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .rowNumber(rowNumber),
        .column(column), .out_image(out_image), .busy(busy), .done(done)
    );

    fmap_row_writer dut_d (
        .clk(clk), .reset_n(reset_n), .start(d_start), .in_valid(d_in_valid),
        .in_ready(d_in_ready), .in_data(d_in_data), .rowNumber(d_row),
        .column(d_col), .out_image(d_image), .busy(d_busy), .done(d_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_img(input string tag, input logic [0:S_OUT-1] obs, input logic [0:S_OUT-1] exp);
        int w;
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            w = 0;
            while (w < S_OUT/DW - 1 && obs[w*DW +: DW] === exp[w*DW +: DW]) w++;
            $error("FAIL %s: word %0d observed %h expected %h", tag, w, obs[w*DW +: DW], exp[w*DW +: DW]);
        end
    endtask

    task automatic chk_dimg(input string tag);
        int w;
        n_chk++;
        assert (d_image === dm_img) else begin
            n_fail++;
            w = 0;
            while (w < D_OUT/DW - 1 && d_image[w*DW +: DW] === dm_img[w*DW +: DW]) w++;
            $error("FAIL %s: word %0d observed %h expected %h", tag, w, d_image[w*DW +: DW], dm_img[w*DW +: DW]);
        end
    endtask

    function automatic logic [0:S_IN-1] rand_in();
        logic [0:S_IN-1] v;
        for (int i = 0; i < S_IN/DW; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // Pixel value whose hex digits read as k, row, col.
    function automatic logic [0:S_IN-1] tag_in(input int r, input int h);
        logic [0:S_IN-1] v;
        for (int k = 0; k < KS; k++)
            for (int j = 0; j < HALF; j++)
                v[(k*HALF+j)*DW +: DW] = DW'(k*256 + r*16 + h*HALF + j);
        return v;
    endfunction

    // One clock on the small instance: drive, advance the reference, compare everything.
    task automatic cyc(input bit st, input bit v, input logic [0:S_IN-1] d, input string tag);
        int r, h;
        start = st; in_valid = v; in_data = d;
        @(negedge clk);
        if (m_done) begin
            m_done = 0;
        end else if (!m_collect) begin
            if (st) begin m_collect = 1; m_beat = 0; end
        end else if (v) begin
            r = m_beat / 2;
            h = m_beat % 2;
            for (int k = 0; k < KS; k++)
                for (int j = 0; j < HALF; j++)
                    m_img[((k*OH + r)*OW + h*HALF + j)*DW +: DW] = d[(k*HALF+j)*DW +: DW];
            m_beat++;
            if (m_beat == 2*OH) begin m_collect = 0; m_done = 1; m_beat = 0; end
        end
        chk({tag, "/in_ready"}, 64'(in_ready), 64'(m_collect));
        chk({tag, "/busy"},     64'(busy),     64'(m_collect));
        chk({tag, "/done"},     64'(done),     64'(m_done));
        chk({tag, "/row"},      64'(rowNumber), 64'(m_beat / 2));
        chk({tag, "/col"},      64'(column),    64'(m_beat % 2));
        chk_img({tag, "/image"}, out_image, m_img);
    endtask

    task automatic finish_map(input string tag);
        int guard = 0;
        while (m_collect && guard < 100) begin
            cyc(0, 1, rand_in(), tag);
            guard++;
        end
        chk({tag, "/completed"}, 64'(m_collect), 64'(0));
        cyc(0, 0, '0, {tag, "_idle"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        start = 0; in_valid = 0; in_data = '0;
        d_start = 0; d_in_valid = 0; d_in_data = '0;
        m_img = '0; m_collect = 0; m_done = 0; m_beat = 0; dm_img = '0;
        repeat (2) @(negedge clk);
        chk("rst/in_ready", 64'(in_ready), 64'(0));
        chk("rst/busy",     64'(busy),     64'(0));
        chk("rst/done",     64'(done),     64'(0));
        chk("rst/row",      64'(rowNumber), 64'(0));
        chk("rst/col",      64'(column),    64'(0));
        chk_img("rst/image", out_image, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // Full map, valid held, tagged pixels.
        cyc(1, 0, '0, "full_start");
        for (int b = 0; b < 2*OH; b++) cyc(0, 1, tag_in(b/2, b%2), "full");
        chk("full/elem133", 64'(out_image[((1*OH+3)*OW+3)*DW +: DW]), 64'h0133);
        chk("full/elem021", 64'(out_image[((0*OH+2)*OW+1)*DW +: DW]), 64'h0021);
        cyc(0, 0, '0, "full_idle");

        // Back-pressure: valid pattern 1,0,0,1.
        cyc(1, 0, '0, "bp_start");
        for (int i = 0; i < 100 && m_collect; i++)
            cyc(0, (i % 4 == 0) || (i % 4 == 3), rand_in(), "bp");
        chk("bp/completed", 64'(m_collect), 64'(0));
        cyc(0, 0, '0, "bp_idle");

        // Idle valid without start does nothing; start+valid together: beat not taken.
        cyc(0, 1, rand_in(), "idle_valid");
        cyc(1, 1, rand_in(), "sv_start");
        chk("sv/row0", 64'(rowNumber), 64'(0));
        chk("sv/col0", 64'(column), 64'(0));
        finish_map("sv");

        // Start during COLLECT is ignored.
        cyc(1, 0, '0, "sc_start");
        for (int b = 0; b < 3; b++) cyc(0, 1, rand_in(), "sc");
        cyc(1, 0, '0, "sc_restart");
        chk("sc/row1", 64'(rowNumber), 64'(1));
        chk("sc/col1", 64'(column), 64'(1));
        cyc(1, 1, rand_in(), "sc_restart_valid");
        finish_map("sc");

        // Second map after done with fresh data; image compare exposes stale words.
        cyc(1, 0, '0, "m2_start");
        finish_map("m2");

        // Async reset mid-map.
        cyc(1, 0, '0, "rm_start");
        for (int b = 0; b < 3; b++) cyc(0, 1, rand_in(), "rm");
        in_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk_img("rm/image", out_image, '0);
        chk("rm/in_ready", 64'(in_ready), 64'(0));
        chk("rm/row",      64'(rowNumber), 64'(0));
        chk("rm/col",      64'(column),    64'(0));
        chk("rm/done",     64'(done),      64'(0));
        chk("rm/busy",     64'(busy),      64'(0));
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_img = '0; m_collect = 0; m_done = 0; m_beat = 0;
        cyc(0, 0, '0, "rm_idle");
        cyc(1, 0, '0, "rm2_start");
        finish_map("rm2");

        // Default-parameter instance: 28 beats per map.
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        chk("def/in_ready", 64'(d_in_ready), 64'(1));
        chk("def/busy",     64'(d_busy),     64'(1));
        for (int b = 0; b < 2*D_OH; b++) begin
            d_in_valid = 1'b1;
            for (int j = 0; j < D_HALF; j++) d_in_data[j*DW +: DW] = DW'($urandom);
            for (int j = 0; j < D_HALF; j++)
                dm_img[((b/2)*D_OH + (b%2)*D_HALF + j)*DW +: DW] = d_in_data[j*DW +: DW];
            @(negedge clk);
            if (b == 2*D_OH-1 || b == 2*D_OH-2)
                chk("def/done", 64'(d_done), 64'(b == 2*D_OH-1));
        end
        d_in_valid = 1'b0;
        chk("def/ready_low", 64'(d_in_ready), 64'(0));
        chk("def/busy_low",  64'(d_busy),     64'(0));
        chk("def/row_wrap",  64'(d_row),      64'(0));
        chk_dimg("def/image");
        @(negedge clk);
        chk("def/done_pulse", 64'(d_done), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
